// File: rtl/cic_d_tdm.sv
// Multi-channel TDM CIC decimator: NUM_CH interleaved channels share one
// integrator/comb datapath, with runtime decimation ratio and an output FWFT FIFO.
module cic_d_tdm #(
  parameter int INP_DW     = 16,
  parameter int OUT_DW     = 32,
  parameter int NUM_CH     = 4,
  parameter int CIC_N      = 3,
  parameter int CIC_M      = 1,
  parameter int CIC_R_MAX  = 16,
  parameter int RATE_DW    = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                                          clk,
  input  logic                                          reset_n,
  input  logic signed [INP_DW-1:0]                      s_axis_in_tdata,
  input  logic                                          s_axis_in_tvalid,
  input  logic                                          s_axis_in_tlast,
  output logic                                          s_axis_in_tready,
  input  logic        [RATE_DW-1:0]                     s_axis_rate_tdata,
  input  logic                                          s_axis_rate_tvalid,
  output logic signed [OUT_DW-1:0]                      m_axis_out_tdata,
  output logic        [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] m_axis_out_tuser,
  output logic                                          m_axis_out_tlast,
  output logic                                          m_axis_out_tvalid,
  input  logic                                          m_axis_out_tready,
  output logic                                          sync_err
);

  localparam int B_MAX = INP_DW + CIC_N * $clog2(CIC_R_MAX * CIC_M);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CH_W-1:0]    LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [RATE_DW-1:0] RATE_MAX = RATE_DW'(CIC_R_MAX);

  typedef logic signed [B_MAX-1:0] acc_t;
  typedef struct packed {
    logic [CH_W-1:0]   ch;
    logic [OUT_DW-1:0] data;
  } fifo_word_t;

  logic [CH_W-1:0]    ch_cnt_q, ch_cnt_d;
  logic [RATE_DW-1:0] dec_cnt_q, dec_cnt_d;
  logic [RATE_DW-1:0] rate_q, rate_d;
  logic [RATE_DW-1:0] rate_pend_q, rate_pend_d;
  logic               pend_vld_q, pend_vld_d;
  logic               started_q, started_d;
  logic               sync_err_q, sync_err_d;
  logic               rdy_en_q;
  logic               accept, last_ch, dec_frame, dec_wrap, push_comb;

  acc_t integ_q [NUM_CH][CIC_N];
  acc_t dly_q   [NUM_CH][CIC_N][CIC_M];
  acc_t integ_new [CIC_N];
  acc_t comb_x    [CIC_N+1];
  acc_t             comb_q;
  logic             comb_vld_q;
  logic [CH_W-1:0]  comb_ch_q;
  logic [OUT_DW-1:0] out_word;

  fifo_word_t        mem_q [FIFO_DEPTH];
  fifo_word_t        head;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              fifo_push, fifo_pop;

  function automatic logic [RATE_DW-1:0] clamp_rate(input logic [RATE_DW-1:0] r);
    logic [RATE_DW-1:0] c;
    c = r;
    if (r == '0)            c = RATE_DW'(1);
    else if (r > RATE_MAX)  c = RATE_MAX;
    return c;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign accept    = s_axis_in_tvalid && s_axis_in_tready;
  assign last_ch   = (ch_cnt_q == LAST_CH);
  assign dec_frame = (dec_cnt_q == rate_q - RATE_DW'(1));
  assign dec_wrap  = accept && last_ch && dec_frame;
  assign push_comb = accept && dec_frame;

  // Integrator chain and comb chain for the channel currently on the bus.
  always_comb begin
    integ_new[0] = integ_q[ch_cnt_q][0] + acc_t'(s_axis_in_tdata);
    for (int k = 1; k < CIC_N; k++)
      integ_new[k] = integ_q[ch_cnt_q][k] + integ_new[k-1];
    comb_x[0] = integ_new[CIC_N-1];
    for (int k = 0; k < CIC_N; k++)
      comb_x[k+1] = comb_x[k] - dly_q[ch_cnt_q][k][CIC_M-1];
  end

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    ch_cnt_d    = ch_cnt_q;
    dec_cnt_d   = dec_cnt_q;
    rate_d      = rate_q;
    rate_pend_d = rate_pend_q;
    pend_vld_d  = pend_vld_q;
    started_d   = started_q;
    sync_err_d  = sync_err_q;
    if (s_axis_rate_tvalid) begin
      rate_pend_d = clamp_rate(s_axis_rate_tdata);
      pend_vld_d  = 1'b1;
    end
    if (accept) begin
      started_d = 1'b1;
      if (s_axis_in_tlast != last_ch) sync_err_d = 1'b1;
      ch_cnt_d = (s_axis_in_tlast || last_ch) ? '0 : ch_cnt_q + CH_W'(1);
      if (last_ch) dec_cnt_d = dec_frame ? '0 : dec_cnt_q + RATE_DW'(1);
    end
    // A new ratio only lands where dec_cnt is zero, so dec_cnt never exceeds rate-1.
    if (pend_vld_d && ((!started_q && !accept) || dec_wrap)) begin
      rate_d     = rate_pend_d;
      pend_vld_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ch_cnt_q    <= '0;
      dec_cnt_q   <= '0;
      rate_q      <= RATE_MAX;
      rate_pend_q <= '0;
      pend_vld_q  <= 1'b0;
      started_q   <= 1'b0;
      sync_err_q  <= 1'b0;
      rdy_en_q    <= 1'b0;
    end else begin
      ch_cnt_q    <= ch_cnt_d;
      dec_cnt_q   <= dec_cnt_d;
      rate_q      <= rate_d;
      rate_pend_q <= rate_pend_d;
      pend_vld_q  <= pend_vld_d;
      started_q   <= started_d;
      sync_err_q  <= sync_err_d;
      rdy_en_q    <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      integ_q    <= '{default: '0};
      dly_q      <= '{default: '0};
      comb_q     <= '0;
      comb_vld_q <= 1'b0;
      comb_ch_q  <= '0;
    end else begin
      if (accept) begin
        for (int k = 0; k < CIC_N; k++) integ_q[ch_cnt_q][k] <= integ_new[k];
      end
      if (push_comb) begin
        for (int k = 0; k < CIC_N; k++) begin
          dly_q[ch_cnt_q][k][0] <= comb_x[k];
          for (int m = 1; m < CIC_M; m++) dly_q[ch_cnt_q][k][m] <= dly_q[ch_cnt_q][k][m-1];
        end
        comb_q    <= comb_x[CIC_N];
        comb_ch_q <= ch_cnt_q;
      end
      comb_vld_q <= push_comb;
    end
  end

  if (OUT_DW <= B_MAX) begin : g_trunc
    assign out_word = comb_q[B_MAX-1 -: OUT_DW];
  end else begin : g_sext
    assign out_word = OUT_DW'(comb_q);
  end

  // Output FIFO, first-word-fall-through.
  assign fifo_push = comb_vld_q;
  assign fifo_pop  = m_axis_out_tvalid && m_axis_out_tready;
  assign count_d   = count_q + CNT_W'(fifo_push) - CNT_W'(fifo_pop);

  // NOTE: the FIFO storage has no reset; count_q gates every read, so stale words are never visible.
  always_ff @(posedge clk) begin
    if (fifo_push) mem_q[wr_ptr_q] <= {comb_ch_q, out_word};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (fifo_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (fifo_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_d;
    end
  end

  // Two free slots: one for the word already in the comb register, one for this beat.
  assign s_axis_in_tready  = rdy_en_q && (count_q <= CNT_W'(FIFO_DEPTH - 2));
  assign head              = mem_q[rd_ptr_q];
  assign m_axis_out_tvalid = (count_q != '0);
  assign m_axis_out_tdata  = m_axis_out_tvalid ? head.data : '0;
  assign m_axis_out_tuser  = m_axis_out_tvalid ? head.ch : '0;
  assign m_axis_out_tlast  = m_axis_out_tvalid && (head.ch == LAST_CH);
  assign sync_err          = sync_err_q;

endmodule
